axicb_mst_switch_wr: RTL and testbench



---
 rtl/axicb_pkg.sv | 13 +
 rtl/axicb_round_robin.sv | 68 ++++++
 rtl/axicb_scfifo.sv | 55 +++++
 rtl/axicb_mst_switch_wr.sv | 143 ++++++++++++++
 tb/tb_axicb_mst_switch_wr.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/axicb_pkg.sv
// Shared constants and types for the crossbar slave-side write switch.
package axicb_pkg;

  localparam int unsigned MST_NB    = 4;
  localparam int unsigned MST_IDX_W = 2;

  typedef logic [MST_IDX_W-1:0] mst_idx_t;

  // B channel layout: {bresp, bid}
  localparam int unsigned BID_LSB = 0;
  localparam int unsigned BRESP_W = 2;

endpackage

// File: rtl/axicb_round_robin.sv
// Round-robin arbiter with grant lock held while the downstream request is pending.
module axicb_round_robin
  import axicb_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic [MST_NB-1:0] req_i,
  input  logic              hold_i,
  input  logic              ack_i,
  output logic [MST_NB-1:0] grant_o,
  output mst_idx_t          grant_idx_o
);

  mst_idx_t          ptr_q, ptr_d;
  logic              lock_q, lock_d;
  logic [MST_NB-1:0] lgrant_q, lgrant_d;
  logic [MST_NB-1:0] rr_grant;
  mst_idx_t          idx;

  // Search starts at the priority pointer and wraps.
  always_comb begin
    rr_grant = '0;
    idx      = '0;
    for (int i = 0; i < int'(MST_NB); i++) begin
      idx = mst_idx_t'(int'(ptr_q) + i);
      if (req_i[idx] && (rr_grant == '0)) rr_grant[idx] = 1'b1;
    end
  end

  always_comb begin
    grant_o     = lock_q ? lgrant_q : rr_grant;
    grant_idx_o = '0;
    for (int i = 0; i < int'(MST_NB); i++) begin
      if (grant_o[i]) grant_idx_o = mst_idx_t'(i);
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    lgrant_d = lgrant_q;
    if (ack_i) begin
      lock_d = 1'b0;
      ptr_d  = mst_idx_t'(grant_idx_o + 1'b1);
    end else if (hold_i) begin
      lock_d   = 1'b1;
      lgrant_d = grant_o;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q    <= '0;
      lock_q   <= 1'b0;
      lgrant_q <= '0;
    end else if (srst) begin
      ptr_q    <= '0;
      lock_q   <= 1'b0;
      lgrant_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      lgrant_q <= lgrant_d;
    end
  end

endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO; full/empty come from registered pointers only.
module axicb_scfifo #(
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned DEPTH_W = 3
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_W:0]   wr_q, wr_d, rd_q, rd_d;
  logic               push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[DEPTH_W] != rd_q[DEPTH_W]) &&
                   (wr_q[DEPTH_W-1:0] == rd_q[DEPTH_W-1:0]);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q[DEPTH_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (srst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset; pointers define validity.
  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wr_q[DEPTH_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/axicb_mst_switch_wr.sv
// Slave-side write switch: RR arbitration on AW, in-order W via grant FIFO, B routed by ID mask.
// Define AXICB_BRESP_DROP_EN to accept and drop responses whose BID matches no master.
module axicb_mst_switch_wr
  import axicb_pkg::*;
#(
  parameter int unsigned AXI_ID_W = 8,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK = 'h10,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK = 'h20,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK = 'h40,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK = 'h80,
  parameter int unsigned WFIFO_DEPTH_W = 3,
  parameter int unsigned AWCH_W = 8,
  parameter int unsigned WCH_W = 8,
  parameter int unsigned BCH_W = AXI_ID_W + 2
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_awvalid,
  output logic [MST_NB-1:0]        i_awready,
  input  logic [MST_NB*AWCH_W-1:0] i_awch,
  input  logic [MST_NB-1:0]        i_wvalid,
  output logic [MST_NB-1:0]        i_wready,
  input  logic [MST_NB-1:0]        i_wlast,
  input  logic [MST_NB*WCH_W-1:0]  i_wch,
  output logic [MST_NB-1:0]        i_bvalid,
  input  logic [MST_NB-1:0]        i_bready,
  output logic [BCH_W-1:0]         i_bch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch,
  input  logic                     o_bvalid,
  output logic                     o_bready,
  input  logic [BCH_W-1:0]         o_bch,
  output logic                     o_bid_err
);

`ifdef AXICB_BRESP_DROP_EN
  localparam logic BRESP_DROP = 1'b1;
`else
  localparam logic BRESP_DROP = 1'b0;
`endif

  logic                           en_q, en_d, active;
  logic                           bid_err_q, bid_err_d;
  logic                           fifo_full, fifo_empty, aw_ack, aw_hold, w_pop, w_en;
  logic [MST_NB-1:0]              aw_req, grant;
  mst_idx_t                       grant_idx, head, bmst;
  logic [MST_NB-1:0]              bmatch;
  logic                           bany;
  logic [AXI_ID_W-1:0]            bid;
  logic [MST_NB-1:0][AXI_ID_W-1:0] masks;

  // Outputs stay quiet during reset and the first cycle after it.
  assign en_d   = ~srst;
  assign active = en_q & ~srst;

  assign aw_req    = (active && !fifo_full) ? i_awvalid : '0;
  assign o_awvalid = active & (|grant);
  assign aw_ack    = o_awvalid & o_awready & ~fifo_full;
  assign aw_hold   = o_awvalid & ~o_awready;
  assign i_awready = (active && o_awready && !fifo_full) ? grant : '0;

  axicb_round_robin u_arb (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .srst        (srst),
    .req_i       (aw_req),
    .hold_i      (aw_hold),
    .ack_i       (aw_ack),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  axicb_scfifo #(.DATA_W(MST_IDX_W), .DEPTH_W(WFIFO_DEPTH_W)) u_wfifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .push_i  (aw_ack),
    .data_i  (grant_idx),
    .full_o  (fifo_full),
    .pop_i   (w_pop),
    .data_o  (head),
    .empty_o (fifo_empty)
  );

  assign w_en     = active & ~fifo_empty;
  assign o_wvalid = w_en & i_wvalid[head];
  assign o_wlast  = i_wlast[head];
  assign w_pop    = o_wvalid & o_wready & o_wlast;

  always_comb begin
    o_awch   = '0;
    o_wch    = '0;
    i_wready = '0;
    for (int n = 0; n < int'(MST_NB); n++) begin
      if (grant[n]) o_awch = i_awch[n*AWCH_W +: AWCH_W];
      if (head == mst_idx_t'(n)) begin
        o_wch       = i_wch[n*WCH_W +: WCH_W];
        i_wready[n] = w_en & o_wready;
      end
    end
  end

  assign masks = {MST3_ID_MASK, MST2_ID_MASK, MST1_ID_MASK, MST0_ID_MASK};
  assign bid   = o_bch[BID_LSB +: AXI_ID_W];
  assign i_bch = o_bch;

  // Lowest-index matching master owns the response.
  always_comb begin
    bmatch = '0;
    bmst   = '0;
    for (int n = int'(MST_NB) - 1; n >= 0; n--) begin
      bmatch[n] = ((bid & masks[n]) == masks[n]);
      if (bmatch[n]) bmst = mst_idx_t'(n);
    end
    bany     = |bmatch;
    i_bvalid = '0;
    i_bvalid[bmst] = active & o_bvalid & bany;
    o_bready = active & (bany ? i_bready[bmst] : BRESP_DROP);
    bid_err_d = bid_err_q | (active & o_bvalid & ~bany);
  end

  assign o_bid_err = bid_err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q      <= 1'b0;
      bid_err_q <= 1'b0;
    end else if (srst) begin
      en_q      <= 1'b0;
      bid_err_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      bid_err_q <= bid_err_d;
    end
  end

endmodule

// File: tb/tb_axicb_mst_switch_wr.sv
// Directed bench for axicb_mst_switch_wr: arbitration, W ordering, FIFO full, B routing, resets.
module tb_axicb_mst_switch_wr;

`ifdef AXICB_BRESP_DROP_EN
  localparam logic EXP_DROP = 1'b1;
`else
  localparam logic EXP_DROP = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn, srst;
  logic [3:0]  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awch, wch;
  logic [9:0]  bch;
  logic        o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready, bid_err;
  logic [7:0]  o_awch, o_wch;
  logic [9:0]  o_bch;
  int          errors = 0;
  int          checks = 0;

  always #5 aclk = ~aclk;

  axicb_mst_switch_wr dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .i_awvalid (awvalid),
    .i_awready (awready),
    .i_awch    (awch),
    .i_wvalid  (wvalid),
    .i_wready  (wready),
    .i_wlast   (wlast),
    .i_wch     (wch),
    .i_bvalid  (bvalid),
    .i_bready  (bready),
    .i_bch     (bch),
    .o_awvalid (o_awvalid),
    .o_awready (o_awready),
    .o_awch    (o_awch),
    .o_wvalid  (o_wvalid),
    .o_wready  (o_wready),
    .o_wlast   (o_wlast),
    .o_wch     (o_wch),
    .o_bvalid  (o_bvalid),
    .o_bready  (o_bready),
    .o_bch     (o_bch),
    .o_bid_err (bid_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0;
    awvalid = 4'b0101; awch = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    wvalid = 4'hF; wlast = 4'h0; wch = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    bready = 4'hF; o_awready = 1'b1; o_wready = 1'b1;
    o_bvalid = 1'b1; o_bch = {2'b00, 8'h10};
    repeat (2) nxt();
    #1;
    chk("rst_awvalid", 32'(o_awvalid), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wvalid", 32'(o_wvalid), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_bready", 32'(o_bready), 0);
    chk("rst_biderr", 32'(bid_err), 0);

    nxt(); aresetn = 1'b1; o_bvalid = 1'b0; wvalid = 4'h0; #1;
    chk("post_rst_awvalid", 32'(o_awvalid), 0);
    chk("post_rst_awready", 32'(awready), 0);

    // Masters 0 and 2 together from pointer 0
    nxt(); #1;
    chk("rr_grant0", 32'(awready), 32'h1);
    chk("rr_awch0", 32'(o_awch), 32'hA0);
    nxt(); awvalid = 4'b0100; #1;
    chk("rr_grant2", 32'(awready), 32'h4);
    chk("rr_awch2", 32'(o_awch), 32'hA2);

    // Pointer now 3: masters 0 and 3 request, slave stalls
    nxt(); awvalid = 4'b1001; o_awready = 1'b0; #1;
    chk("ptr3_awvalid", 32'(o_awvalid), 1);
    chk("ptr3_awch", 32'(o_awch), 32'hA3);
    chk("stall_awready", 32'(awready), 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); awvalid = 4'b1011; #1;
      chk("lock_awch", 32'(o_awch), 32'hA3);
      chk("lock_awready", 32'(awready), 0);
    end
    nxt(); o_awready = 1'b1; #1;
    chk("lock_release", 32'(awready), 32'h8);

    // W order: FIFO holds 0,2,3; master 2 presents first
    nxt(); awvalid = 4'h0; wvalid = 4'b0100; wlast = 4'b0100; #1;
    chk("w_order_valid", 32'(o_wvalid), 0);
    chk("w_order_ready", 32'(wready), 32'h1);
    nxt(); wvalid = 4'b0101; wch[7:0] = 8'hB0; #1;
    chk("w0_valid", 32'(o_wvalid), 1);
    chk("w0_data", 32'(o_wch), 32'hB0);
    chk("w0_last", 32'(o_wlast), 0);
    nxt(); wlast = 4'b0101; wch[7:0] = 8'hB1; #1;
    chk("w0_last2", 32'(o_wlast), 1);
    chk("w0_data2", 32'(o_wch), 32'hB1);
    nxt(); wvalid = 4'b0100; #1;
    chk("w2_b2b_valid", 32'(o_wvalid), 1);
    chk("w2_ready", 32'(wready), 32'h4);
    chk("w2_data", 32'(o_wch), 32'hD2);
    nxt(); wvalid = 4'h0; wlast = 4'h0; #1;
    chk("w3_head_ready", 32'(wready), 32'h8);
    chk("w3_idle", 32'(o_wvalid), 0);
    nxt(); wvalid = 4'b1000; wlast = 4'b1000; #1;
    chk("w3_data", 32'(o_wch), 32'hD3);
    nxt(); wvalid = 4'h0; wlast = 4'h0; awvalid = 4'b0010; #1;
    chk("w_empty_ready", 32'(wready), 0);

    // Fill the 8-deep grant FIFO from master 1
    for (int i = 0; i < 8; i++) begin
      chk("fill_awready", 32'(awready), 32'h2);
      nxt(); #1;
    end
    chk("full_awready", 32'(awready), 0);
    chk("full_awvalid", 32'(o_awvalid), 0);
    nxt(); wvalid = 4'b0010; wlast = 4'b0010; #1;
    chk("full_pop_same", 32'(awready), 0);
    chk("full_pop_wvalid", 32'(o_wvalid), 1);
    nxt(); wvalid = 4'h0; #1;
    chk("after_pop_awready", 32'(awready), 32'h2);

    // Async reset mid-burst
    nxt(); awvalid = 4'h0; wvalid = 4'b0010; wlast = 4'h0; #1;
    chk("mid_burst_wvalid", 32'(o_wvalid), 1);
    aresetn = 1'b0; #1;
    chk("arst_wvalid", 32'(o_wvalid), 0);
    chk("arst_wready", 32'(wready), 0);
    nxt(); aresetn = 1'b1; awvalid = 4'b0110; wlast = 4'b0010; #1;
    chk("arst_first_cycle", 32'(o_awvalid), 0);
    nxt(); #1;
    chk("arst_ptr0", 32'(awready), 32'h2);
    chk("arst_fifo_empty", 32'(o_wvalid), 0);
    nxt(); awvalid = 4'h0; #1;
    chk("w_latency_valid", 32'(o_wvalid), 1);
    chk("w_latency_ready", 32'(wready), 32'h2);

    // B routing
    nxt(); wvalid = 4'h0; wlast = 4'h0; o_bvalid = 1'b1; o_bch = {2'b10, 8'h25}; bready = 4'b0010; #1;
    chk("b25_bvalid", 32'(bvalid), 32'h2);
    chk("b25_bready", 32'(o_bready), 1);
    chk("b25_bch", 32'(bch), 32'h225);
    bready = 4'b1101; #1;
    chk("b25_bready_low", 32'(o_bready), 0);
    o_bch = {2'b01, 8'h30}; bready = 4'b0001; #1;
    chk("b30_lowest", 32'(bvalid), 32'h1);
    chk("b30_bready", 32'(o_bready), 1);
    chk("b30_noerr", 32'(bid_err), 0);
    o_bch = {2'b00, 8'h05}; bready = 4'hF; #1;
    chk("b05_bvalid", 32'(bvalid), 0);
    chk("b05_bready", 32'(o_bready), 32'(EXP_DROP));
    nxt();
    chk("b05_err", 32'(bid_err), 1);
    o_bvalid = 1'b0;
    nxt();
    chk("b05_err_sticky", 32'(bid_err), 1);

    // Synchronous reset
    srst = 1'b1; awvalid = 4'hF; #1;
    chk("srst_awvalid", 32'(o_awvalid), 0);
    nxt();
    chk("srst_biderr", 32'(bid_err), 0);
    srst = 1'b0; #1;
    chk("srst_first_cycle", 32'(awready), 0);
    nxt(); #1;
    chk("srst_ptr0", 32'(awready), 32'h1);
    awvalid = 4'h0;
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
